// File: rtl/trap_pkg.sv
// Shared definitions for the external trap request controller.
//   state_e   : controller state (IDLE / REQ / SERVICE)
//   TRAP_ID_W : width of the trap id presented to the core
//   MAX_SRC   : largest supported number of interrupt sources
//   prio_enc  : index of the lowest set bit (lowest index = highest priority)
package trap_pkg;

    localparam int unsigned TRAP_ID_W = 5;
    localparam int unsigned MAX_SRC   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // Scan from the top so the last hit is the lowest set index.
    function automatic logic [TRAP_ID_W-1:0] prio_enc(input logic [MAX_SRC-1:0] vec);
        logic [TRAP_ID_W-1:0] idx;
        idx = '0;
        for (int i = int'(MAX_SRC) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = TRAP_ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser, one chain per bit.
//   clk, rst : clock, synchronous active-high reset
//   d_i      : asynchronous input vector
//   q_o      : synchronised output (DEPTH cycles later)
module sync_ff #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/trap_req_ctrl.sv
// External trap request controller: synchronises interrupt sources, keeps
// edge sources sticky-pending, picks the lowest-index enabled source and
// holds a request to the core until ack, then waits for end-of-interrupt.
//   clk, rst          : clock, synchronous active-high reset
//   src_i             : asynchronous interrupt sources
//   en_we_i/en_wdata_i: enable mask write
//   en_o, pend_o      : current enable mask / pending vector
//   ex_trap_o         : trap request to the core
//   trap_id_o         : index of the requesting source
//   trap_ack_i, eoi_i : core took the trap / handler finished
//   busy_o            : not idle
//   ack_to_o          : one-cycle pulse when ack is overdue
module trap_req_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned       NUM_SRC     = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK  = '1,
    parameter int unsigned       ACK_TO      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_i,
    input  logic                 en_we_i,
    input  logic [NUM_SRC-1:0]   en_wdata_i,
    output logic [NUM_SRC-1:0]   en_o,
    output logic [NUM_SRC-1:0]   pend_o,
    output logic                 ex_trap_o,
    output logic [TRAP_ID_W-1:0] trap_id_o,
    input  logic                 trap_ack_i,
    input  logic                 eoi_i,
    output logic                 busy_o,
    output logic                 ack_to_o
);

    localparam int unsigned CNT_W = (ACK_TO > 0) ? $clog2(ACK_TO + 1) : 1;

    logic [NUM_SRC-1:0]   src_s;
    logic [NUM_SRC-1:0]   hist_q;
    logic [NUM_SRC-1:0]   pend_q, pend_d;
    logic [NUM_SRC-1:0]   en_q, en_d;
    logic [NUM_SRC-1:0]   eligible;
    logic                 ack_take;

    state_e               state_q, state_d;
    logic                 ex_trap_q, ex_trap_d;
    logic [TRAP_ID_W-1:0] trap_id_q, trap_id_d;
    logic                 busy_q, busy_d;
    logic                 ack_to_q, ack_to_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    sync_ff #(
        .WIDTH (NUM_SRC),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (src_i),
        .q_o (src_s)
    );

    assign eligible = pend_q & en_q;
    assign ack_take = (state_q == REQ) && trap_ack_i;

    // Pending update: edge sources are sticky (set beats ack-clear), level sources follow s.
    always_comb begin
        pend_d = pend_q;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (EDGE_MASK[k]) begin
                pend_d[k] = (src_s[k] && !hist_q[k]) ||
                            (pend_q[k] && !(ack_take && (trap_id_q == TRAP_ID_W'(k))));
            end else begin
                pend_d[k] = src_s[k];
            end
        end
    end

    assign en_d = en_we_i ? en_wdata_i : en_q;

    // Next state and registered outputs.
    always_comb begin
        state_d   = state_q;
        ex_trap_d = ex_trap_q;
        trap_id_d = trap_id_q;
        cnt_d     = '0;
        ack_to_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d   = REQ;
                    ex_trap_d = 1'b1;
                    trap_id_d = prio_enc(MAX_SRC'(eligible));
                end
            end
            REQ: begin
                if (trap_ack_i) begin
                    state_d   = SERVICE;
                    ex_trap_d = 1'b0;
                end else if (ACK_TO != 0) begin
                    // Saturates at ACK_TO so the pulse fires only once per request.
                    cnt_d    = (cnt_q == CNT_W'(ACK_TO)) ? cnt_q : cnt_q + CNT_W'(1);
                    ack_to_d = (cnt_q == CNT_W'(ACK_TO - 1));
                end
            end
            SERVICE: begin
                if (eoi_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                ex_trap_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            state_q   <= IDLE;
            ex_trap_q <= 1'b0;
            trap_id_q <= '0;
            busy_q    <= 1'b0;
            ack_to_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hist_q    <= src_s;
            pend_q    <= pend_d;
            en_q      <= en_d;
            state_q   <= state_d;
            ex_trap_q <= ex_trap_d;
            trap_id_q <= trap_id_d;
            busy_q    <= busy_d;
            ack_to_q  <= ack_to_d;
            cnt_q     <= cnt_d;
        end
    end

    assign en_o      = en_q;
    assign pend_o    = pend_q;
    assign ex_trap_o = ex_trap_q;
    assign trap_id_o = trap_id_q;
    assign busy_o    = busy_q;
    assign ack_to_o  = ack_to_q;

endmodule
